// File: rtl/adc_fft_if_pkg.sv
// adc_fft_if_pkg: shared state encoding and defaults for the adc_fft_if frame loader
package adc_fft_if_pkg;
    localparam int RWIDTH_DEF    = 16;
    localparam int FRAME_LEN_DEF = 256;
    localparam int FRAME_CNT_W   = 16;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_STREAM = 2'd1, ST_GAP = 2'd2} state_e;
endpackage

// File: rtl/adc_fft_if_fft_frame_loader.sv
// adc_fft_if_fft_frame_loader: pops whole frames from an FWFT FIFO and streams them to the FFT core
//   clk, rst            clock, synchronous active-high reset
//   enable_i            allow new frames to launch
//   fifo_dout_i         FIFO head word, valid while fifo_empty_i=0
//   fifo_empty_i        FIFO empty flag
//   fifo_count_i        words held in the FIFO
//   fifo_rd_en_o        combinational pop strobe
//   fft_ready_i         FFT core can accept a new frame
//   fft_start_o         pulse with sample 0
//   fft_dvalid_o        fft_data_o carries a sample
//   fft_data_o          sample to the FFT core
//   fft_last_o          high with the final sample of a frame
//   frame_cnt_o         completed frames, wrapping
//   underrun_o          sticky flag: a slot was emitted while the FIFO was empty
//   underrun_clr_i      clears underrun_o
module adc_fft_if_fft_frame_loader
    import adc_fft_if_pkg::*;
#(
    parameter int RWIDTH    = RWIDTH_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CNTW      = 12,
    parameter int GAP_CYC   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable_i,
    input  logic [RWIDTH-1:0]      fifo_dout_i,
    input  logic                   fifo_empty_i,
    input  logic [CNTW-1:0]        fifo_count_i,
    output logic                   fifo_rd_en_o,
    input  logic                   fft_ready_i,
    output logic                   fft_start_o,
    output logic                   fft_dvalid_o,
    output logic [RWIDTH-1:0]      fft_data_o,
    output logic                   fft_last_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o,
    output logic                   underrun_o,
    input  logic                   underrun_clr_i
);
    localparam int IDXW = $clog2(FRAME_LEN);
    localparam int GAPW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(FRAME_LEN - 1);
    localparam logic [GAPW-1:0] GAP_LAST = GAPW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CNTW:0]   FL_EXT   = (CNTW + 1)'(FRAME_LEN);

    state_e                 state_q, state_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [GAPW-1:0]        gap_q, gap_d;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic                   ur_q, ur_d;
    logic                   dv_q, dv_d, start_q, start_d, last_q, last_d;
    logic [RWIDTH-1:0]      data_q, data_d;
    logic                   stream, idx_last, pop, launch;

    always_comb begin
        stream   = state_q == ST_STREAM;
        idx_last = idx_q == IDX_LAST;
        pop      = stream & ~fifo_empty_i & ~rst;
        // The word popped this cycle is still counted, so discount it when
        // judging whether a full frame remains for a back-to-back launch.
        launch   = enable_i & fft_ready_i & ({1'b0, fifo_count_i} >= FL_EXT + {{CNTW{1'b0}}, pop});
        state_d  = state_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        cnt_d    = cnt_q;
        ur_d     = (ur_q & ~underrun_clr_i) | (stream & fifo_empty_i);
        dv_d     = stream;
        start_d  = stream & (idx_q == '0);
        last_d   = stream & idx_last;
        data_d   = (stream & ~fifo_empty_i) ? fifo_dout_i : '0;
        if (state_q == ST_IDLE) begin
            state_d = launch ? ST_STREAM : ST_IDLE;
        end else if (stream) begin
            idx_d = idx_last ? '0 : idx_q + 1'b1;
            if (idx_last) begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (GAP_CYC > 0) ? ST_GAP : (launch ? ST_STREAM : ST_IDLE);
            end
        end else begin
            gap_d   = (gap_q == GAP_LAST) ? '0 : gap_q + 1'b1;
            state_d = (gap_q == GAP_LAST) ? ST_IDLE : ST_GAP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            ur_q    <= 1'b0;
            dv_q    <= 1'b0;
            start_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            ur_q    <= ur_d;
            dv_q    <= dv_d;
            start_q <= start_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign fifo_rd_en_o = pop;
    assign fft_start_o  = start_q;
    assign fft_dvalid_o = dv_q;
    assign fft_last_o   = last_q;
    assign fft_data_o   = data_q;
    assign frame_cnt_o  = cnt_q;
    assign underrun_o   = ur_q;
endmodule

// File: tb/tb_adc_fft_if_fft_frame_loader.sv
// tb_adc_fft_if_fft_frame_loader: two loaders (gap 2 and gap 0) fed by queue FIFOs and checked by a frame-level scoreboard
module tb_adc_fft_if_fft_frame_loader;
    localparam int FL = 8;
    localparam int GAP0 = 2;
    localparam int GAP1 = 0;

    typedef struct {
        logic        en, rdy;
        logic        dv, st, ls;
        logic [15:0] data, fc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic en[2], rdy[2], clr[2], fe_force[2];
    logic [15:0] dout[2];
    logic empty[2];
    logic [11:0] cnt[2];
    logic rd[2], start[2], dv[2], last[2], ur[2];
    logic [15:0] data[2], fcnt[2];

    logic [15:0] q0[$], q1[$], sb0[$], sb1[$];
    int ncmp = 0, nbad = 0;
    int pos[2], idle[2];
    bit seen[2];
    logic [15:0] frames[2];
    logic urm[2], p[2], e[2], c[2], rs;
    vec_t tbl[12];

    always #5 clk = ~clk;

    adc_fft_if_fft_frame_loader #(.RWIDTH(16), .FRAME_LEN(FL), .CNTW(12), .GAP_CYC(GAP0)) u0 (
        .clk(clk), .rst(rst), .enable_i(en[0]), .fifo_dout_i(dout[0]), .fifo_empty_i(empty[0]),
        .fifo_count_i(cnt[0]), .fifo_rd_en_o(rd[0]), .fft_ready_i(rdy[0]), .fft_start_o(start[0]),
        .fft_dvalid_o(dv[0]), .fft_data_o(data[0]), .fft_last_o(last[0]), .frame_cnt_o(fcnt[0]),
        .underrun_o(ur[0]), .underrun_clr_i(clr[0]));

    adc_fft_if_fft_frame_loader #(.RWIDTH(16), .FRAME_LEN(FL), .CNTW(12), .GAP_CYC(GAP1)) u1 (
        .clk(clk), .rst(rst), .enable_i(en[1]), .fifo_dout_i(dout[1]), .fifo_empty_i(empty[1]),
        .fifo_count_i(cnt[1]), .fifo_rd_en_o(rd[1]), .fft_ready_i(rdy[1]), .fft_start_o(start[1]),
        .fft_dvalid_o(dv[1]), .fft_data_o(data[1]), .fft_last_o(last[1]), .frame_cnt_o(fcnt[1]),
        .underrun_o(ur[1]), .underrun_clr_i(clr[1]));

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic upd();
        empty[0] = (q0.size() == 0) | fe_force[0];
        dout[0]  = (q0.size() > 0) ? q0[0] : 16'h0;
        cnt[0]   = 12'(q0.size());
        empty[1] = (q1.size() == 0) | fe_force[1];
        dout[1]  = (q1.size() > 0) ? q1[0] : 16'h0;
        cnt[1]   = 12'(q1.size());
    endtask

    task automatic push(input int k, input logic [15:0] w);
        if (k == 0) begin q0.push_back(w); sb0.push_back(w); end
        else begin q1.push_back(w); sb1.push_back(w); end
    endtask

    task automatic model(input int k);
        logic [15:0] w;
        int gapv;
        gapv = (k == 0) ? GAP0 : GAP1;
        if (rs) begin
            pos[k] = 0; idle[k] = 0; seen[k] = 0; frames[k] = 0; urm[k] = 0;
            cmp($sformatf("d%0d_rst_dv", k), dv[k], 0);
            cmp($sformatf("d%0d_rst_start", k), start[k], 0);
            cmp($sformatf("d%0d_rst_last", k), last[k], 0);
            cmp($sformatf("d%0d_rst_data", k), data[k], 0);
            cmp($sformatf("d%0d_rst_fcnt", k), fcnt[k], 0);
            cmp($sformatf("d%0d_rst_ur", k), ur[k], 0);
            return;
        end
        urm[k] = (urm[k] & ~c[k]) | (dv[k] & e[k]);
        if (dv[k]) begin
            if (e[k]) w = 16'h0;
            else if (k == 0) w = (sb0.size() > 0) ? sb0.pop_front() : 16'hDEAD;
            else w = (sb1.size() > 0) ? sb1.pop_front() : 16'hDEAD;
            if (pos[k] == 0 && seen[k]) cmp($sformatf("d%0d_gap", k), idle[k] >= gapv, 1);
            cmp($sformatf("d%0d_start", k), start[k], pos[k] == 0);
            cmp($sformatf("d%0d_last", k), last[k], pos[k] == FL - 1);
            cmp($sformatf("d%0d_data", k), data[k], w);
            idle[k] = 0;
            pos[k]++;
            if (pos[k] == FL) begin pos[k] = 0; frames[k]++; seen[k] = 1; end
        end else begin
            cmp($sformatf("d%0d_idle_start", k), start[k], 0);
            cmp($sformatf("d%0d_idle_last", k), last[k], 0);
            cmp($sformatf("d%0d_bubble", k), pos[k], 0);
            idle[k]++;
        end
        cmp($sformatf("d%0d_ur", k), ur[k], urm[k]);
        cmp($sformatf("d%0d_fcnt", k), fcnt[k], frames[k]);
    endtask

    task automatic tick();
        upd();
        #1;
        for (int k = 0; k < 2; k++) begin p[k] = rd[k]; e[k] = empty[k]; c[k] = clr[k]; end
        rs = rst;
        if (rs) for (int k = 0; k < 2; k++) cmp($sformatf("d%0d_rd_in_rst", k), p[k], 0);
        @(posedge clk);
        #1;
        if (p[0]) void'(q0.pop_front());
        if (p[1]) void'(q1.pop_front());
        if (rs) begin sb0 = q0; sb1 = q1; end
        model(0);
        model(1);
        upd();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_start(input int k, input int lim, input string nm);
        bit f = 0;
        for (int i = 0; i < lim && !f; i++) begin
            tick();
            f = dv[k] & start[k];
        end
        cmp(nm, f, 1);
    endtask

    task automatic wait_pos(input int k, input int n, input string nm);
        bit f = (pos[k] == n);
        for (int i = 0; i < 20 && !f; i++) begin
            tick();
            f = (pos[k] == n);
        end
        cmp(nm, f, 1);
    endtask

    initial begin
        int nd, first, lastt;
        logic [15:0] fb;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            en[k] = 0; rdy[k] = 0; clr[k] = 0; fe_force[k] = 0;
            pos[k] = 0; idle[k] = 0; seen[k] = 0; frames[k] = 0; urm[k] = 0;
        end
        upd();
        @(posedge clk);
        #1;
        ticks(2);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            tbl[i].en = 1; tbl[i].rdy = 1;
            tbl[i].dv = (i >= 1 && i <= 8);
            tbl[i].st = (i == 1);
            tbl[i].ls = (i == 8);
            tbl[i].data = (i >= 1 && i <= 8) ? 16'(i) : 16'h0;
            tbl[i].fc = (i >= 8) ? 16'd1 : 16'd0;
        end
        for (int i = 1; i <= 8; i++) push(0, 16'(i));
        for (int i = 0; i < 12; i++) begin
            en[0] = tbl[i].en; rdy[0] = tbl[i].rdy;
            tick();
            cmp($sformatf("basic%0d_dv", i), dv[0], tbl[i].dv);
            cmp($sformatf("basic%0d_start", i), start[0], tbl[i].st);
            cmp($sformatf("basic%0d_last", i), last[0], tbl[i].ls);
            cmp($sformatf("basic%0d_data", i), data[0], tbl[i].data);
            cmp($sformatf("basic%0d_fcnt", i), fcnt[0], tbl[i].fc);
        end

        for (int i = 0; i < 7; i++) push(0, 16'h0011 + 16'(i));
        for (int i = 0; i < 20; i++) begin
            tick();
            cmp("gate7_rd", p[0], 0);
            cmp("gate7_dv", dv[0], 0);
        end
        push(0, 16'h0018);
        wait_start(0, 3, "gate8_launch");
        ticks(12);

        rdy[0] = 0;
        for (int i = 0; i < 16; i++) push(0, 16'h0101 + 16'(i));
        for (int i = 0; i < 10; i++) begin
            tick();
            cmp("rdy0_dv", dv[0], 0);
        end
        fb = frames[0];
        rdy[0] = 1;
        wait_start(0, 3, "rdy1_launch");
        cmp("rdy1_first", data[0], 16'h0101);
        wait_pos(0, 3, "rdy_drop_pos");
        rdy[0] = 0;
        ticks(12);
        cmp("rdy_drop_done", fcnt[0], fb + 16'd1);
        nd = 0;
        for (int i = 0; i < 10; i++) begin tick(); nd += int'(dv[0]); end
        cmp("rdy_drop_hold", nd, 0);
        rdy[0] = 1;
        ticks(14);

        for (int i = 0; i < 8; i++) push(0, 16'h0201 + 16'(i));
        wait_start(0, 3, "ur_launch");
        wait_pos(0, 4, "ur_pos");
        fe_force[0] = 1;
        tick();
        fe_force[0] = 0;
        cmp("ur_slot_dv", dv[0], 1);
        cmp("ur_slot_data", data[0], 0);
        cmp("ur_flag", ur[0], 1);
        ticks(12);
        cmp("ur_sticky", ur[0], 1);
        clr[0] = 1;
        tick();
        clr[0] = 0;
        cmp("ur_clr", ur[0], 0);
        for (int i = 0; i < 7; i++) push(0, 16'h0209 + 16'(i));
        ticks(14);

        for (int i = 0; i < 8; i++) push(0, 16'h0301 + 16'(i));
        wait_start(0, 3, "rst_launch");
        wait_pos(0, 4, "rst_pos");
        rst = 1;
        tick();
        cmp("rst_mid_dv", dv[0], 0);
        q0.delete(); sb0.delete();
        tick();
        rst = 0;
        for (int i = 0; i < 8; i++) push(0, 16'h0401 + 16'(i));
        wait_start(0, 3, "rst_relaunch");
        cmp("rst_relaunch_data", data[0], 16'h0401);
        ticks(12);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0 && q0.size() < 40) push(0, 16'($urandom));
            en[0] = $urandom_range(0, 7) != 0;
            rdy[0] = $urandom_range(0, 3) != 0;
            clr[0] = $urandom_range(0, 15) == 0;
            fe_force[0] = $urandom_range(0, 31) == 0;
            tick();
        end
        clr[0] = 0; fe_force[0] = 0; en[0] = 0;
        ticks(12);

        en[1] = 1; rdy[1] = 1;
        for (int i = 0; i < 24; i++) push(1, 16'h0501 + 16'(i));
        nd = 0; first = -1; lastt = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dv[1]) begin
                nd++;
                if (first < 0) first = i;
                lastt = i;
            end
        end
        cmp("b2b_count", nd, 24);
        cmp("b2b_span", lastt - first + 1, 24);
        cmp("b2b_fcnt", fcnt[1], 3);

        force u1.cnt_q = 16'hFFFE;
        frames[1] = 16'hFFFE;
        tick();
        release u1.cnt_q;
        tick();
        cmp("wrap_preset", fcnt[1], 16'hFFFE);
        for (int i = 0; i < 16; i++) push(1, 16'h0601 + 16'(i));
        ticks(30);
        cmp("wrap_fcnt", fcnt[1], 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
